// File: rtl/core_run_ctrl_pkg.sv
// Shared encodings for the core run controller:
// host opcodes, controller states, stop reasons, core states.
package core_run_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_RUN        = 3'd1,
    CMD_HALT       = 3'd2,
    CMD_STEP       = 3'd3,
    CMD_RESET_CORE = 3'd4,
    CMD_SET_BP     = 3'd5,
    CMD_CLR_BP     = 3'd6
  } cmd_op_e;

  typedef enum logic [2:0] {
    RS_RESETTING = 3'd0,
    RS_INITTING  = 3'd1,
    RS_STOPPED   = 3'd2,
    RS_RUNNING   = 3'd3,
    RS_STEPPING  = 3'd4,
    RS_DRAIN     = 3'd5
  } run_state_e;

  typedef enum logic [2:0] {
    STOP_NONE       = 3'd0,
    STOP_RESET      = 3'd1,
    STOP_HOST       = 3'd2,
    STOP_STEP_DONE  = 3'd3,
    STOP_BREAKPOINT = 3'd4,
    STOP_CORE_HALT  = 3'd5,
    STOP_CORE_ERROR = 3'd6
  } stop_reason_e;

  localparam logic [2:0] CS_INIT      = 3'd0;
  localparam logic [2:0] CS_FETCH     = 3'd1;
  localparam logic [2:0] CS_DECODE    = 3'd2;
  localparam logic [2:0] CS_EXECUTE   = 3'd3;
  localparam logic [2:0] CS_MEMORY    = 3'd4;
  localparam logic [2:0] CS_WRITEBACK = 3'd5;
  localparam logic [2:0] CS_HALT      = 3'd6;
  localparam logic [2:0] CS_ERROR     = 3'd7;

endpackage

// File: rtl/core_run_ctrl.sv
// Run/halt/step/reset sequencer for the RV32I core,
// with one PC breakpoint and a retired-instruction counter.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int COUNT_W    = 32,
  parameter int RST_CYCLES = 2,
  parameter bit AUTORUN    = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [31:0]        cmd_arg,
  output logic               core_rst_n,
  output logic               core_clk_enable,
  input  logic               core_cycle_end,
  input  logic [2:0]         core_dbg_state,
  input  logic [31:0]        core_dbg_pc,
  output logic [2:0]         run_state,
  output logic [2:0]         stop_reason,
  output logic               stopped_pulse,
  output logic               cmd_err,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

  run_state_e   state_q, state_d;
  stop_reason_e why_q, why_d, stop_why;
  logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic               crst_q, crst_d;
  logic               first_q, first_d;
  logic               bp_en_q, bp_en_d;
  logic [31:0]        bp_addr_q, bp_addr_d;
  logic               bp_skip_q, bp_skip_d;
  logic [31:0]        step_q, step_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               err_q, err_d;
  logic               acc, retire, at_bp, bp_block, stop_now;
  cmd_op_e            op;

  assign op       = cmd_op_e'(cmd_op);
  assign at_bp    = core_dbg_state == CS_FETCH
                 && core_dbg_pc == bp_addr_q;
  assign bp_block = bp_en_q && !bp_skip_q && at_bp;
  assign retire   = core_clk_enable && core_cycle_end
                 && core_dbg_state == CS_WRITEBACK;
  assign acc      = cmd_valid && cmd_ready;

  assign cmd_ready = state_q == RS_STOPPED
                  || state_q == RS_RUNNING
                  || state_q == RS_STEPPING;

  // Init stops feeding clocks once the core reaches FETCH,
  // so it parks on the first instruction boundary.
  always_comb begin
    core_clk_enable = 1'b0;
    unique case (state_q)
      RS_RESETTING: core_clk_enable = 1'b1;
      RS_INITTING:  core_clk_enable = core_dbg_state != CS_FETCH;
      RS_STOPPED:   core_clk_enable = 1'b0;
      default:      core_clk_enable = !bp_block;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    why_d     = why_q;
    rst_cnt_d = rst_cnt_q;
    crst_d    = crst_q;
    first_d   = first_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    bp_skip_d = bp_skip_q;
    step_d    = step_q;
    cnt_d     = retire ? cnt_q + COUNT_W'(1) : cnt_q;
    err_d     = 1'b0;
    stop_now  = 1'b0;
    stop_why  = STOP_NONE;
    if (retire) bp_skip_d = 1'b0;
    unique case (state_q)
      RS_RESETTING: begin
        crst_d = 1'b0;
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          rst_cnt_d = '0;
          crst_d    = 1'b1;
          state_d   = RS_INITTING;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      RS_INITTING: begin
        if (core_dbg_state == CS_FETCH) begin
          first_d = 1'b0;
          if (AUTORUN && first_q) begin
            state_d = RS_RUNNING;
          end else begin
            state_d = RS_STOPPED;
            why_d   = STOP_RESET;
          end
        end
      end
      RS_STOPPED: begin
        if (acc) begin
          unique case (op)
            CMD_RUN: begin
              state_d   = RS_RUNNING;
              bp_skip_d = at_bp;
            end
            CMD_STEP: begin
              state_d   = RS_STEPPING;
              step_d    = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
              bp_skip_d = at_bp;
            end
            CMD_RESET_CORE: begin
              state_d   = RS_RESETTING;
              crst_d    = 1'b0;
              rst_cnt_d = '0;
              cnt_d     = '0;
            end
            CMD_NOP, CMD_SET_BP, CMD_CLR_BP: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      default: begin
        if (state_q == RS_STEPPING && retire)
          step_d = step_q - 32'd1;
        if (core_dbg_state == CS_ERROR) begin
          stop_now = 1'b1;
          stop_why = STOP_CORE_ERROR;
        end else if (core_dbg_state == CS_HALT) begin
          stop_now = 1'b1;
          stop_why = STOP_CORE_HALT;
        end else if (state_q == RS_STEPPING && retire
                     && step_q == 32'd1) begin
          stop_now = 1'b1;
          stop_why = STOP_STEP_DONE;
        end else if (state_q == RS_DRAIN && retire) begin
          stop_now = 1'b1;
          stop_why = STOP_HOST;
        end else if (bp_block) begin
          stop_now = 1'b1;
          stop_why = STOP_BREAKPOINT;
        end
        if (stop_now) begin
          state_d = RS_STOPPED;
          why_d   = stop_why;
          err_d   = acc && op != CMD_NOP;
        end else if (acc) begin
          unique case (op)
            CMD_HALT: state_d = RS_DRAIN;
            CMD_NOP, CMD_SET_BP, CMD_CLR_BP: ;
            default: err_d = 1'b1;
          endcase
        end
      end
    endcase
    if (acc && !stop_now) begin
      if (op == CMD_SET_BP) begin
        bp_addr_d = cmd_arg;
        bp_en_d   = 1'b1;
      end
      if (op == CMD_CLR_BP) bp_en_d = 1'b0;
    end
    pulse_d = state_d == RS_STOPPED && state_q != RS_STOPPED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RS_RESETTING;
      why_q     <= STOP_NONE;
      rst_cnt_q <= '0;
      crst_q    <= 1'b0;
      first_q   <= 1'b1;
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
      bp_skip_q <= 1'b0;
      step_q    <= '0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      why_q     <= why_d;
      rst_cnt_q <= rst_cnt_d;
      crst_q    <= crst_d;
      first_q   <= first_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      bp_skip_q <= bp_skip_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
    end
  end

  assign core_rst_n    = crst_q;
  assign run_state     = state_q;
  assign stop_reason   = why_q;
  assign stopped_pulse = pulse_q;
  assign cmd_err       = err_q;
  assign instr_count   = cnt_q;

endmodule
